// File: rtl/argmax_pkg.sv
// Shared constants and helpers for the argmax compare tree.
package argmax_pkg;

    localparam int ARGMAX_DEF_WIDTH = 21;
    localparam int ARGMAX_NO_WINNER = 0;

    function automatic int argmax_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/argmax_tree_if.sv
// Sample-set / result bundle of argmax_tree. i_thresh exists only when
// ARGMAX_TREE_THRESH_EN is defined.
interface argmax_tree_if
    import argmax_pkg::*;
#(
    parameter int P_WIDTH  = ARGMAX_DEF_WIDTH,
    parameter int P_NUM_IN = 8
);
    localparam int IW = argmax_clog2(P_NUM_IN + 1);

    logic                         i_valid;
    logic [P_NUM_IN*P_WIDTH-1:0]  i_data;
`ifdef ARGMAX_TREE_THRESH_EN
    logic [P_WIDTH-1:0]           i_thresh;
`endif
    logic                         o_valid;
    logic [P_WIDTH-1:0]           o_max;
    logic [IW-1:0]                o_index;

    modport master (
`ifdef ARGMAX_TREE_THRESH_EN
        output i_thresh,
`endif
        output i_valid, i_data,
        input  o_valid, o_max, o_index
    );

    modport slave (
`ifdef ARGMAX_TREE_THRESH_EN
        input  i_thresh,
`endif
        input  i_valid, i_data,
        output o_valid, o_max, o_index
    );

endinterface

// File: rtl/argmax_node.sv
// One tree level: compare two value/index pairs and register the winner.
// Side a always carries the lower channel indices, so a tie keeps side a.
module argmax_node
    import argmax_pkg::*;
#(
    parameter int P_WIDTH = ARGMAX_DEF_WIDTH,
    parameter int P_IW    = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_vld,
    input  logic [P_WIDTH-1:0] i_val_a,
    input  logic [P_IW-1:0]    i_idx_a,
    input  logic [P_WIDTH-1:0] i_val_b,
    input  logic [P_IW-1:0]    i_idx_b,
    output logic               o_vld,
    output logic [P_WIDTH-1:0] o_val,
    output logic [P_IW-1:0]    o_idx
);

    logic               r_vld_p1;
    logic [P_WIDTH-1:0] r_val_p1;
    logic [P_IW-1:0]    r_idx_p1;
    logic               w_a_wins;

    assign w_a_wins = (i_val_a >= i_val_b);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= i_vld;
        end
    end

    // Data only moves with a valid set; no reset needed on the datapath.
    always_ff @(posedge i_clk) begin
        if (i_vld) begin
            r_val_p1 <= w_a_wins ? i_val_a : i_val_b;
            r_idx_p1 <= w_a_wins ? i_idx_a : i_idx_b;
        end
    end

    assign o_vld = r_vld_p1;
    assign o_val = r_val_p1;
    assign o_idx = r_idx_p1;

endmodule

// File: rtl/argmax_tree.sv
// Pipelined argmax over P_NUM_IN channels, latency ceil(log2(P_NUM_IN)).
// Define ARGMAX_TREE_THRESH_EN to add i_thresh (index forced to 0 below it).
module argmax_tree
    import argmax_pkg::*;
#(
    parameter int P_WIDTH  = ARGMAX_DEF_WIDTH,
    parameter int P_NUM_IN = 8
) (
    input logic          i_clk,
    input logic          i_rst,
    argmax_tree_if.slave io_bus
);

    localparam int L  = argmax_clog2(P_NUM_IN);
    localparam int IW = argmax_clog2(P_NUM_IN + 1);
    localparam int NP = 1 << L;

    // Heap numbering: node n has children 2n (lower channels) and 2n+1.
    // Leaves are NP..2NP-1, registered nodes 2..NP-1, node 1 is the final stage.
    logic [P_WIDTH-1:0] w_val [2:2*NP-1];
    logic [IW-1:0]      w_idx [2:2*NP-1];
    logic [2*NP-1:1]    w_vld;

    logic               w_a_wins;
    logic [P_WIDTH-1:0] w_root_val;
    logic [IW-1:0]      w_root_idx;
    logic               w_no_win;

    logic               r_valid;
    logic [P_WIDTH-1:0] r_max;
    logic [IW-1:0]      r_index;

    for (genvar k = 0; k < NP; k++) begin : g_leaf
        if (k < P_NUM_IN) begin : g_real
            assign w_val[NP+k] = io_bus.i_data[k*P_WIDTH +: P_WIDTH];
            assign w_idx[NP+k] = IW'(k + 1);
        end else begin : g_pad
            assign w_val[NP+k] = '0;
            assign w_idx[NP+k] = IW'(ARGMAX_NO_WINNER);
        end
        assign w_vld[NP+k] = io_bus.i_valid;
    end

    for (genvar n = 2; n < NP; n++) begin : g_node
        argmax_node #(
            .P_WIDTH (P_WIDTH),
            .P_IW    (IW)
        ) u_node (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_vld   (w_vld[2*n] & w_vld[2*n+1]),
            .i_val_a (w_val[2*n]),
            .i_idx_a (w_idx[2*n]),
            .i_val_b (w_val[2*n+1]),
            .i_idx_b (w_idx[2*n+1]),
            .o_vld   (w_vld[n]),
            .o_val   (w_val[n]),
            .o_idx   (w_idx[n])
        );
    end

    assign w_vld[1] = w_vld[2] & w_vld[3];

`ifdef ARGMAX_TREE_THRESH_EN
    logic [P_WIDTH-1:0] w_thr_root;

    // Threshold rides alongside its set; stage k matches node depth L-1-k.
    if (L > 1) begin : g_thr
        logic [P_WIDTH-1:0] r_thr_p [L-1];

        always_ff @(posedge i_clk) begin
            if (io_bus.i_valid) r_thr_p[0] <= io_bus.i_thresh;
            for (int k = 1; k < L - 1; k++) begin
                if (w_vld[1 << (L-k)]) r_thr_p[k] <= r_thr_p[k-1];
            end
        end

        assign w_thr_root = r_thr_p[L-2];
    end else begin : g_thr_bypass
        assign w_thr_root = io_bus.i_thresh;
    end
`endif

    // Final stage: last compare plus the no-winner decision.
    assign w_a_wins   = (w_val[2] >= w_val[3]);
    assign w_root_val = w_a_wins ? w_val[2] : w_val[3];
    assign w_root_idx = w_a_wins ? w_idx[2] : w_idx[3];

    always_comb begin
        w_no_win = (w_root_val == '0);
`ifdef ARGMAX_TREE_THRESH_EN
        if (w_root_val < w_thr_root) w_no_win = 1'b1;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_max   <= '0;
            r_index <= '0;
        end else begin
            r_valid <= w_vld[1];
            if (w_vld[1]) begin
                r_max   <= w_root_val;
                r_index <= w_no_win ? IW'(ARGMAX_NO_WINNER) : w_root_idx;
            end
        end
    end

    assign io_bus.o_valid = r_valid;
    assign io_bus.o_max   = r_max;
    assign io_bus.o_index = r_index;

endmodule

// File: tb/tb_argmax_tree.sv
// Directed bench for argmax_tree: an 8-channel instance (table vectors,
// gaps, reset) and a 5-channel instance (padded leaves, full-width max).
module tb_argmax_tree;
    import argmax_pkg::*;

    localparam int W  = 21;
    localparam int N  = 8;
    localparam int N5 = 5;
    localparam int NV = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    argmax_tree_if #(.P_WIDTH(W), .P_NUM_IN(N))  bus8 ();
    argmax_tree_if #(.P_WIDTH(W), .P_NUM_IN(N5)) bus5 ();

    argmax_tree #(.P_WIDTH(W), .P_NUM_IN(N)) dut8 (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus8.slave)
    );

    argmax_tree #(.P_WIDTH(W), .P_NUM_IN(N5)) dut5 (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus5.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] data;
        logic [W-1:0]   mx;
        logic [3:0]     idx;
    } vec_t;

    vec_t tbl [NV];

    function automatic logic [N*W-1:0] mk8(input int c0, input int c1, input int c2,
                                           input int c3, input int c4, input int c5,
                                           input int c6, input int c7);
        return {W'(c7), W'(c6), W'(c5), W'(c4), W'(c3), W'(c2), W'(c1), W'(c0)};
    endfunction

    function automatic logic [N5*W-1:0] mk5(input int c0, input int c1, input int c2,
                                            input int c3, input int c4);
        return {W'(c4), W'(c3), W'(c2), W'(c1), W'(c0)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pulses;
    int pat [5] = '{1, 0, 1, 1, 0};

    initial begin
        tbl[0] = '{mk8(5, 9, 3, 9, 0, 1, 2, 7),           21'd9,        4'd2};
        tbl[1] = '{mk8(0, 0, 0, 0, 0, 0, 0, 0),           21'd0,        4'd0};
        tbl[2] = '{mk8(100, 1, 2, 3, 4, 5, 6, 7),         21'd100,      4'd1};
        tbl[3] = '{mk8(1, 2, 3, 4, 5, 6, 7, 200),         21'd200,      4'd8};
        tbl[4] = '{mk8(10, 20, 30, 'h1FFFFF, 0, 0, 0, 0), 21'h1FFFFF,   4'd4};
        tbl[5] = '{mk8(0, 0, 0, 0, 0, 50, 49, 50),        21'd50,       4'd6};
        tbl[6] = '{mk8(7, 7, 7, 7, 7, 7, 7, 7),           21'd7,        4'd1};
        tbl[7] = '{mk8(0, 0, 0, 0, 0, 0, 1, 0),           21'd1,        4'd7};

        // Reset with i_valid held high: those sets must be ignored.
        rst          = 1'b1;
        bus8.i_valid = 1'b1;
        bus8.i_data  = tbl[0].data;
        bus5.i_valid = 1'b0;
        bus5.i_data  = '0;
`ifdef ARGMAX_TREE_THRESH_EN
        bus8.i_thresh = '0;
        bus5.i_thresh = '0;
`endif
        repeat (3) tick();
        chk("reset o_valid", 32'(bus8.o_valid), 32'd0);
        chk("reset o_max",   32'(bus8.o_max),   32'd0);
        chk("reset o_index", 32'(bus8.o_index), 32'd0);
        rst          = 1'b0;
        bus8.i_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus8.o_valid) pulses++;
        end
        chk("valid during reset ignored", 32'(pulses), 32'd0);

        // Table vectors back-to-back; each result appears 3 edges later.
        for (int i = 0; i < NV + 2; i++) begin
            bus8.i_valid = (i < NV);
            bus8.i_data  = tbl[i % NV].data;
            tick();
            if (i >= 2) begin
                chk($sformatf("vec%0d o_valid", i - 2), 32'(bus8.o_valid), 32'd1);
                chk($sformatf("vec%0d o_max",   i - 2), 32'(bus8.o_max),   32'(tbl[i-2].mx));
                chk($sformatf("vec%0d o_index", i - 2), 32'(bus8.o_index), 32'(tbl[i-2].idx));
            end else begin
                chk($sformatf("latency cycle%0d o_valid", i), 32'(bus8.o_valid), 32'd0);
            end
        end
        bus8.i_valid = 1'b0;

        // Idle: outputs hold the last result.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold o_valid", 32'(bus8.o_valid), 32'd0);
            chk("hold o_max",   32'(bus8.o_max),   32'd1);
            chk("hold o_index", 32'(bus8.o_index), 32'd7);
        end

        // Gaps in i_valid reappear as gaps in o_valid.
        for (int i = 0; i < 7; i++) begin
            bus8.i_valid = (i < 5) ? pat[i][0] : 1'b0;
            bus8.i_data  = tbl[i % NV].data;
            tick();
            chk($sformatf("gap cycle%0d o_valid", i), 32'(bus8.o_valid),
                (i >= 2) ? 32'(pat[i-2]) : 32'd0);
            if (i >= 2 && pat[i-2] == 1)
                chk($sformatf("gap cycle%0d o_index", i), 32'(bus8.o_index), 32'(tbl[i-2].idx));
        end

        // Reset one cycle after two valid sets discards both.
        bus8.i_valid = 1'b1;
        bus8.i_data  = tbl[2].data;
        tick();
        bus8.i_data  = tbl[3].data;
        tick();
        bus8.i_valid = 1'b0;
        rst          = 1'b1;
        tick();
        chk("mid reset o_valid", 32'(bus8.o_valid), 32'd0);
        chk("mid reset o_max",   32'(bus8.o_max),   32'd0);
        chk("mid reset o_index", 32'(bus8.o_index), 32'd0);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus8.o_valid) pulses++;
        end
        chk("in-flight sets discarded", 32'(pulses), 32'd0);
        chk("after reset o_max",   32'(bus8.o_max),   32'd0);
        chk("after reset o_index", 32'(bus8.o_index), 32'd0);

        // Five channels: padded leaves never win, full-width value survives.
        bus5.i_valid = 1'b1;
        bus5.i_data  = mk5(3, 1, 2, 0, 'h1FFFFF);
        tick();
        bus5.i_data  = mk5(0, 0, 0, 0, 0);
        chk("n5 latency c0", 32'(bus5.o_valid), 32'd0);
        tick();
        bus5.i_data  = mk5('h1FFFFF, 0, 0, 0, 'h1FFFFF);
        chk("n5 latency c1", 32'(bus5.o_valid), 32'd0);
        tick();
        bus5.i_valid = 1'b0;
        chk("n5 ch4 o_valid", 32'(bus5.o_valid), 32'd1);
        chk("n5 ch4 o_max",   32'(bus5.o_max),   32'h1FFFFF);
        chk("n5 ch4 o_index", 32'(bus5.o_index), 32'd5);
        tick();
        chk("n5 zero o_valid", 32'(bus5.o_valid), 32'd1);
        chk("n5 zero o_max",   32'(bus5.o_max),   32'd0);
        chk("n5 zero o_index", 32'(bus5.o_index), 32'd0);
        tick();
        chk("n5 tie o_max",   32'(bus5.o_max),   32'h1FFFFF);
        chk("n5 tie o_index", 32'(bus5.o_index), 32'd1);
        tick();
        chk("n5 idle o_valid", 32'(bus5.o_valid), 32'd0);

`ifdef ARGMAX_TREE_THRESH_EN
        // Threshold travels with its own set.
        bus8.i_valid  = 1'b1;
        bus8.i_data   = mk8(10, 2, 0, 0, 0, 0, 0, 0);
        bus8.i_thresh = 21'd10;
        tick();
        bus8.i_data   = mk8(0, 9, 0, 0, 0, 0, 0, 0);
        bus8.i_thresh = 21'd5;
        tick();
        bus8.i_data   = mk8(9, 0, 0, 0, 0, 0, 0, 0);
        bus8.i_thresh = 21'd10;
        tick();
        bus8.i_valid  = 1'b0;
        bus8.i_thresh = 21'd100;
        chk("thr max10 o_max",   32'(bus8.o_max),   32'd10);
        chk("thr max10 o_index", 32'(bus8.o_index), 32'd1);
        tick();
        chk("thr 9vs5 o_max",   32'(bus8.o_max),   32'd9);
        chk("thr 9vs5 o_index", 32'(bus8.o_index), 32'd2);
        tick();
        chk("thr 9vs10 o_max",   32'(bus8.o_max),   32'd9);
        chk("thr 9vs10 o_index", 32'(bus8.o_index), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
